// File: rtl/tea_req_arbiter.sv
// Two-requester round-robin front end for a fixed-latency TEA decryptor.
// Tags {valid,id} travel alongside the datapath so results come back labelled and in order.
module tea_req_arbiter #(
  parameter int LATENCY = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  logic        req0_valid,
  input  logic [63:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [63:0] req1_data,
  output logic        req1_ready,
  output logic        tea_ena,
  output logic [63:0] tea_in,
  input  logic [63:0] tea_out,
  output logic        out_valid,
  output logic        out_id,
  output logic [63:0] out_data,
  output logic [5:0]  inflight,
  output logic        flush_done
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic               last_grant;
  logic               grant_any;
  logic               grant_id;
  logic               accept_ok;
  logic               accept;
  logic               retire;
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_id;

  assign tea_ena   = !hold && !rst;
  assign out_valid = tag_valid[LATENCY-1] && !rst;
  assign out_id    = tag_id[LATENCY-1];
  assign out_data  = tea_out;
  assign retire    = out_valid && tea_ena;

  // With both requesters pending the pointer picks the one not served last.
  always_comb begin
    grant_any = req0_valid || req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      flush_done <= (state != DONE) && (state_next == DONE);
    end
  end

  // Hold stalls every transition except draining to DONE once nothing is in flight.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush && !hold) state_next = DRAIN;
      DRAIN:   if (inflight == 6'd0) state_next = DONE;
      DONE:    if (!flush && !hold) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    accept_ok  = (state == RUN) && !hold && !rst && !flush;
    accept     = accept_ok && grant_any;
    req0_ready = accept_ok && grant_any && !grant_id;
    req1_ready = accept_ok && grant_any && grant_id;
    if (accept) begin
      tea_in = grant_id ? req1_data : req0_data;
    end else begin
      tea_in = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else if (tea_ena) begin
      tag_valid <= {tag_valid[LATENCY-2:0], accept};
      tag_id    <= {tag_id[LATENCY-2:0], grant_id};
    end
  end

  // Saturating guards keep the count inside 0..LATENCY even if tags and count ever disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 6'd0;
    end else begin
      case ({accept, retire})
        2'b10:   if (inflight != 6'(LATENCY)) inflight <= inflight + 6'd1;
        2'b01:   if (inflight != 6'd0) inflight <= inflight - 6'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_req_arbiter.sv
// Directed bench for tea_req_arbiter: a delay-line model stands in for the decryptor,
// stimulus pushes hand-computed results into a queue and a monitor retires them.
module tb_tea_req_arbiter;

  localparam int          LAT = 32;
  localparam logic [63:0] KEY = 64'h0123_4567_89ab_cdef;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        flush;
  logic        req0_valid;
  logic [63:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [63:0] req1_data;
  logic        req1_ready;
  logic        tea_ena;
  logic [63:0] tea_in;
  logic [63:0] tea_out;
  logic        out_valid;
  logic        out_id;
  logic [63:0] out_data;
  logic [5:0]  inflight;
  logic        flush_done;

  typedef struct {
    logic        id;
    logic [63:0] data;
    int          exp_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          base = 0;
  logic [63:0] dp [LAT];

  tea_req_arbiter #(.LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .flush      (flush),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tea_ena    (tea_ena),
    .tea_in     (tea_in),
    .tea_out    (tea_out),
    .out_valid  (out_valid),
    .out_id     (out_id),
    .out_data   (out_data),
    .inflight   (inflight),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Decryptor stand-in: a LAT-deep delay line that only moves when enabled.
  always @(posedge clk) begin
    if (tea_ena) begin
      for (int i = LAT - 1; i > 0; i--) dp[i] <= dp[i-1];
      dp[0] <= tea_in ^ KEY;
    end
  end
  assign tea_out = dp[LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && tea_ena) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_out: got out_valid=1 id=%0d expected no pending result", out_id);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("out_id", 64'(out_id), 64'(e.id));
        checkOutput("out_data", out_data, e.data);
        checkOutput("out_cycle", 64'(cyc), 64'(e.exp_cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, check readies at negedge and record the results that should come back.
  task automatic applyStimulus(input logic v0, input logic [63:0] d0, input logic v1,
                               input logic [63:0] d1, input logic h, input logic f,
                               input logic er0, input logic er1, input int exp_rel);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    hold       = h;
    flush      = f;
    @(negedge clk);
    checkOutput("req0_ready", 64'(req0_ready), 64'(er0));
    checkOutput("req1_ready", 64'(req1_ready), 64'(er1));
    if (er0 && v0) exp_q.push_back('{1'b0, d0 ^ KEY, base + exp_rel});
    if (er1 && v1) exp_q.push_back('{1'b1, d1 ^ KEY, base + exp_rel});
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) begin
      rst        = 1'b1;
      hold       = 1'b0;
      flush      = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      @(negedge clk);
      checkOutput("rst_tea_ena", 64'(tea_ena), 64'd0);
      checkOutput("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      step();
    end
    rst        = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic drainWait(input string name);
    int n;
    n = 0;
    applyStimulus(0, 64'd0, 0, 64'd0, 0, 0, 0, 0, 0);
    while (!(exp_q.size() == 0 && inflight == 6'd0) && n < 300) begin
      step();
      applyStimulus(0, 64'd0, 0, 64'd0, 0, 0, 0, 0, 0);
      n++;
    end
    if (n >= 300) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
    end
    checkOutput({name, "_inflight"}, 64'(inflight), 64'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    step();
    doReset(2);
    @(negedge clk);
    checkOutput("reset_inflight", 64'(inflight), 64'd0);
    checkOutput("reset_flush_done", 64'(flush_done), 64'd0);
    checkOutput("reset_tea_ena", 64'(tea_ena), 64'd1);
    step();

    $display("[TB] single req0 block");
    base = cyc;
    applyStimulus(1, 64'hA0A0_1111_2222_3333, 0, 64'd0, 0, 0, 1, 0, 32);
    step();
    for (int c = 1; c <= 33; c++) begin
      applyStimulus(0, 64'd0, 0, 64'd0, 0, 0, 0, 0, 0);
      if (c == 1) checkOutput("single_inflight", 64'(inflight), 64'd1);
      checkOutput("single_out_valid", 64'(out_valid), 64'(c == 32));
      step();
    end
    drainWait("single");

    $display("[TB] alternating grants");
    doReset(1);
    base = cyc;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1, 64'h1000_0000_0000_0000 + 64'(c), 1, 64'h2000_0000_0000_0000 + 64'(c),
                    0, 0, (c % 2) == 0, (c % 2) == 1, c + 32);
      step();
    end
    applyStimulus(0, 64'd0, 0, 64'd0, 0, 0, 0, 0, 0);
    checkOutput("rr_inflight_peak", 64'(inflight), 64'd8);
    step();
    drainWait("rr");

    $display("[TB] hold stall");
    base = cyc;
    for (int c = 0; c < 46; c++) begin
      applyStimulus(c < 4, 64'h3000_0000_0000_0000 + 64'(c), 0, 64'd0,
                    (c >= 10 && c <= 14), 0, c < 4, 0, c + 37);
      checkOutput("hold_out_valid", 64'(out_valid), 64'(c >= 37 && c <= 40));
      step();
    end
    drainWait("hold");

    $display("[TB] flush drain");
    doReset(1);
    base = cyc;
    for (int c = 0; c < 48; c++) begin
      applyStimulus(1, 64'h4000_0000_0000_0000 + 64'(c), 0, 64'd0,
                    0, (c >= 5 && c < 46), (c < 5 || c == 47), 0, c + 32);
      checkOutput("flush_done", 64'(flush_done), 64'(c == 38));
      step();
    end
    drainWait("flush");

    $display("[TB] reset mid-flight");
    doReset(1);
    base = cyc;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(c < 10, 64'h5000_0000_0000_0000 + 64'(c), 0, 64'd0, 0, 0, c < 10, 0, c + 32);
      if (c == 11) checkOutput("pre_rst_inflight", 64'(inflight), 64'd10);
      step();
    end
    doReset(1);
    base = cyc;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(0, 64'd0, 0, 64'd0, 0, 0, 0, 0, 0);
      if (c == 0) checkOutput("post_rst_inflight", 64'(inflight), 64'd0);
      checkOutput("post_rst_out_valid", 64'(out_valid), 64'd0);
      step();
    end

    $display("[TB] full load");
    base = cyc;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1, 64'h6000_0000_0000_0000 + 64'(c), 1, 64'h7000_0000_0000_0000 + 64'(c),
                    0, 0, (c % 2) == 0, (c % 2) == 1, c + 32);
      checkOutput("one_ready", 64'(req0_ready & req1_ready), 64'd0);
      if (c >= 32) checkOutput("full_inflight", 64'(inflight), 64'd32);
      step();
    end
    drainWait("full");

    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tea_req_arbiter.md
TEA_REQ_ARBITER -- requirements
Module: tea_req_arbiter

Interface
REQ-001 Parameter LATENCY, default 32, fixed cycle count from tea_in sample to the matching tea_out on the shared decryptor datapath.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 hold  in  1  global stall; freezes the datapath and all tag state.
REQ-006 flush  in  1  level request to stop accepting and drain in-flight blocks.
REQ-007 req0_valid / req1_valid  in  1  requester has a block.
REQ-008 req0_data / req1_data  in  64  ciphertext block.
REQ-009 req0_ready / req1_ready  out  1  block accepted this cycle when valid and ready are both high.
REQ-010 tea_ena  out  1  datapath enable.
REQ-011 tea_in  out  64  block presented to the datapath.
REQ-012 tea_out  in  64  datapath result.
REQ-013 out_valid  out  1  out_data carries a real result this cycle.
REQ-014 out_id  out  1  requester index of the result.
REQ-015 out_data  out  64  plaintext, equal to tea_out.
REQ-016 inflight  out  6  accepted blocks not yet delivered, range 0..LATENCY.
REQ-017 flush_done  out  1  one-cycle pulse when the drain completes.

Function
REQ-018 tea_ena SHALL equal !hold and !rst, so the datapath advances every unstalled cycle, with bubbles when no block is accepted.
REQ-019 The tag pipeline SHALL be a LATENCY-deep shift register of {valid,id} that shifts when tea_ena=1, with stage 0 loaded with {accept,grant_id}.
REQ-020 Signal mapping: out_valid = last-stage valid, out_id = last-stage id, out_data = tea_out; all three are combinational from the tags.
REQ-021 tea_in SHALL carry the granted requester's data and 0 when nothing is granted.
REQ-022 Arbitration SHALL be round-robin with a 1-bit last_grant pointer.
REQ-023 When both requesters are valid, the one not equal to last_grant wins.
REQ-024 When a single requester is valid, it wins regardless of the pointer.
REQ-025 last_grant SHALL update only on an accept.
REQ-026 At most one ready SHALL be high per cycle, and no ready is high unless state=RUN and hold=0.
REQ-027 Ready SHALL NOT depend on the other requester's valid except through the grant.
REQ-028 FSM states SHALL be RUN, DRAIN and DONE.
REQ-029 RUN->DRAIN on flush=1; no accepts in DRAIN or DONE.
REQ-030 DRAIN->DONE when inflight=0 (it may be 0 on entry).
REQ-031 flush_done SHALL pulse for one cycle on entry to DONE.
REQ-032 DONE->RUN when flush=0, and DONE holds while flush=1.
REQ-033 hold=1 SHALL freeze FSM transitions except the inflight=0 check.
REQ-034 inflight SHALL increment on accept only, decrement on out_valid with tea_ena=1 only, and stay unchanged when both happen in the same cycle.
REQ-035 inflight SHALL never exceed LATENCY and never wrap below 0.
REQ-036 While hold=1, out_valid SHALL remain as stored and is not consumed again; the consumer samples only when tea_ena=1.
REQ-037 Results SHALL leave in acceptance order.

Reset
REQ-038 On rst, all tag valids, inflight and flush_done SHALL be 0, with state=RUN and last_grant=1 (req0 wins first).
REQ-039 During rst, tea_ena, both readies and out_valid SHALL be 0.
REQ-040 Reset mid-operation SHALL discard in-flight tags, so stale datapath contents are never flagged valid.
REQ-041 The first LATENCY outputs after reset SHALL be flagged invalid unless blocks were accepted.

Verification
REQ-042 Reset, then req0 only with data A at cycle 0 -> out_valid=1, out_id=0, out_data=tea_out at cycle 32 (LATENCY), and inflight returns to 0 afterwards.
REQ-043 Both valid continuously for 8 cycles -> grants 0,1,0,1,0,1,0,1, outputs in the same id order 32 cycles later, and inflight peaks at 8.
REQ-044 Accept at cycles 0..3, hold=1 for cycles 10..14 -> outputs appear at cycles 37..40, and out_valid never duplicates.
REQ-045 Continuous req0 traffic with flush at cycle 5 -> ready low from cycle 5, flush_done pulses when the 5th result retires, and DONE holds until flush drops.
REQ-046 rst asserted for 1 cycle with inflight=10 -> inflight=0, and no out_valid for the next 32 cycles without new accepts.
REQ-047 Simultaneous accept and retire at full load -> inflight stays at 32, and the ready rule is held.
